// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control unit. Each instruction walks FETCH/DECODE/EXEC/MEM/WB
// so one ALU and one memory port are shared across cycles. Memory uses a
// req/ready handshake guarded by a wait-cycle watchdog; illegal opcodes trap.
//
// State table:
//   state  | meaning
//   FETCH  | read instruction; on mem_ready load IR and advance PC by 4
//   DECODE | legality check, pick EXEC or WB (LUI)
//   EXEC   | ALU op; branch resolution; JAL PC redirect
//   MEM    | load/store data access
//   WB     | one-cycle register file write
//   TRAP   | illegal instruction or memory timeout; held until rst
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   opcode, funct3, funct7_5    IR fields
//   cero                        ALU zero flag (EXEC)
//   mem_ready                   memory completes the pending request
//   mem_req, MEM_RD, MEM_WR     memory request and direction
//   ir_wr, pc_wr, REG_WR        register enables
//   S_Mux_A/B/C                 PC source, ALU B source, writeback source
//   control_ALU                 ALU operation
//   state_o                     current state encoding
//   illegal_op, timeout_err     sticky error flags
module multicycle_control_unit #(
  parameter int ALU_OP_W   = 4,
  parameter int TIMEOUT    = 255,
  parameter int ENABLE_JAL = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [6:0]          opcode,
  input  logic [2:0]          funct3,
  input  logic                funct7_5,
  input  logic                cero,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                MEM_RD,
  output logic                MEM_WR,
  output logic                ir_wr,
  output logic                pc_wr,
  output logic [1:0]          S_Mux_A,
  output logic [1:0]          S_Mux_B,
  output logic [1:0]          S_Mux_C,
  output logic                REG_WR,
  output logic [ALU_OP_W-1:0] control_ALU,
  output logic [2:0]          state_o,
  output logic                illegal_op,
  output logic                timeout_err
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [ALU_OP_W-1:0] ALU_ADD = ALU_OP_W'(0);
  localparam logic [ALU_OP_W-1:0] ALU_SUB = ALU_OP_W'(1);
  localparam logic [ALU_OP_W-1:0] ALU_AND = ALU_OP_W'(2);
  localparam logic [ALU_OP_W-1:0] ALU_OR  = ALU_OP_W'(3);
  localparam logic [ALU_OP_W-1:0] ALU_XOR = ALU_OP_W'(4);
  localparam logic [ALU_OP_W-1:0] ALU_SLT = ALU_OP_W'(5);
  localparam logic [ALU_OP_W-1:0] ALU_SLL = ALU_OP_W'(6);
  localparam logic [ALU_OP_W-1:0] ALU_SRL = ALU_OP_W'(7);
  localparam logic [ALU_OP_W-1:0] ALU_SRA = ALU_OP_W'(8);

  // Counter only needs to reach TIMEOUT, where it saturates.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

  state_t           state, state_next;
  logic [CNT_W-1:0] wait_cnt;
  logic             set_illegal, set_timeout;
  logic             wd_expired;
  logic             op_legal;

  // alt selects SUB for funct3=000 and SRA for funct3=101
  function automatic logic [ALU_OP_W-1:0] alu_sel(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_sel = alt ? ALU_SUB : ALU_ADD;
      3'b111:  alu_sel = ALU_AND;
      3'b110:  alu_sel = ALU_OR;
      3'b100:  alu_sel = ALU_XOR;
      3'b010:  alu_sel = ALU_SLT;
      3'b001:  alu_sel = ALU_SLL;
      3'b101:  alu_sel = alt ? ALU_SRA : ALU_SRL;
      default: alu_sel = ALU_ADD;
    endcase
  endfunction

  always_comb begin
    op_legal = 1'b0;
    case (opcode)
      OP_R, OP_I, OP_LD, OP_ST, OP_LUI: op_legal = 1'b1;
      OP_BR:  op_legal = (funct3 == 3'b000) || (funct3 == 3'b001);
      OP_JAL: op_legal = (ENABLE_JAL != 0);
      default: op_legal = 1'b0;
    endcase
  end

  // Expiry only matters while waiting; a same-cycle mem_ready wins.
  assign wd_expired = (TIMEOUT > 0) && (wait_cnt == CNT_LIMIT) && !mem_ready;

  always_comb begin
    state_next  = state;
    mem_req     = 1'b0;
    MEM_RD      = 1'b0;
    MEM_WR      = 1'b0;
    ir_wr       = 1'b0;
    pc_wr       = 1'b0;
    S_Mux_A     = 2'b00;
    S_Mux_B     = 2'b00;
    S_Mux_C     = 2'b00;
    REG_WR      = 1'b0;
    control_ALU = ALU_ADD;
    set_illegal = 1'b0;
    set_timeout = 1'b0;

    case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        MEM_RD  = 1'b1;
        if (mem_ready) begin
          ir_wr      = 1'b1;
          pc_wr      = 1'b1;
          state_next = S_DECODE;
        end else if (wd_expired) begin
          set_timeout = 1'b1;
          state_next  = S_TRAP;
        end
      end
      S_DECODE: begin
        if (!op_legal) begin
          set_illegal = 1'b1;
          state_next  = S_TRAP;
        end else if (opcode == OP_LUI) begin
          state_next = S_WB;
        end else begin
          state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        state_next = S_FETCH;
        case (opcode)
          OP_R: begin
            control_ALU = alu_sel(funct3, funct7_5);
            state_next  = S_WB;
          end
          OP_I: begin
            S_Mux_B     = 2'b01;
            control_ALU = alu_sel(funct3, funct7_5 && (funct3 == 3'b101));
            state_next  = S_WB;
          end
          OP_LD: begin
            S_Mux_B    = 2'b01;
            state_next = S_MEM;
          end
          OP_ST: begin
            S_Mux_B    = 2'b10;
            state_next = S_MEM;
          end
          OP_BR: begin
            control_ALU = ALU_SUB;
            S_Mux_A     = 2'b01;
            // funct3[0]: 0 = BEQ, 1 = BNE
            pc_wr       = funct3[0] ? !cero : cero;
          end
          OP_JAL: begin
            pc_wr      = 1'b1;
            S_Mux_A    = 2'b10;
            state_next = S_WB;
          end
          default: state_next = S_FETCH;
        endcase
      end
      S_MEM: begin
        mem_req = 1'b1;
        MEM_RD  = (opcode == OP_LD);
        MEM_WR  = (opcode == OP_ST);
        if (mem_ready) begin
          state_next = (opcode == OP_LD) ? S_WB : S_FETCH;
        end else if (wd_expired) begin
          set_timeout = 1'b1;
          state_next  = S_TRAP;
        end
      end
      S_WB: begin
        REG_WR     = 1'b1;
        state_next = S_FETCH;
        case (opcode)
          OP_LUI: begin
            S_Mux_C = 2'b00;
            S_Mux_B = 2'b11;
          end
          OP_LD:   S_Mux_C = 2'b10;
          OP_JAL:  S_Mux_C = 2'b11;
          default: S_Mux_C = 2'b01;
        endcase
      end
      S_TRAP:  state_next = S_TRAP;
      default: state_next = S_FETCH;
    endcase

    // Everything quiet while reset is held, regardless of stale state.
    if (rst) begin
      mem_req     = 1'b0;
      MEM_RD      = 1'b0;
      MEM_WR      = 1'b0;
      ir_wr       = 1'b0;
      pc_wr       = 1'b0;
      S_Mux_A     = 2'b00;
      S_Mux_B     = 2'b00;
      S_Mux_C     = 2'b00;
      REG_WR      = 1'b0;
      control_ALU = ALU_ADD;
      set_illegal = 1'b0;
      set_timeout = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_FETCH;
      wait_cnt    <= '0;
      illegal_op  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_next;
      if (set_illegal) illegal_op  <= 1'b1;
      if (set_timeout) timeout_err <= 1'b1;
      if (mem_req && mem_ready)
        wait_cnt <= '0;
      else if (mem_req && (TIMEOUT > 0) && (wait_cnt != CNT_LIMIT))
        wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] opcode = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       funct7_5 = 1'b0;
  logic       cero = 1'b0;
  logic       mem_ready = 1'b0;

  logic       mem_req, MEM_RD, MEM_WR, ir_wr, pc_wr, REG_WR;
  logic [1:0] S_Mux_A, S_Mux_B, S_Mux_C;
  logic [3:0] control_ALU;
  logic [2:0] state_o;
  logic       illegal_op, timeout_err;

  logic       nj_mem_req, nj_MEM_RD, nj_MEM_WR, nj_ir_wr, nj_pc_wr, nj_REG_WR;
  logic [1:0] nj_S_Mux_A, nj_S_Mux_B, nj_S_Mux_C;
  logic [3:0] nj_control_ALU;
  logic [2:0] nj_state_o;
  logic       nj_illegal_op, nj_timeout_err;

  int n_cmp = 0;
  int n_bad = 0;

  // observations from run_instr
  int         obs_cycles, obs_regwr;
  logic       obs_trap, obs_req_gap, obs_memwr, obs_ex_pcwr;
  logic [3:0] obs_ex_alu;
  logic [1:0] obs_ex_muxa, obs_ex_muxb, obs_wb_muxc, obs_wb_muxb;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  always #5 clk = ~clk;

  multicycle_control_unit #(.ALU_OP_W(4), .TIMEOUT(4), .ENABLE_JAL(1)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .cero(cero), .mem_ready(mem_ready), .mem_req(mem_req), .MEM_RD(MEM_RD),
    .MEM_WR(MEM_WR), .ir_wr(ir_wr), .pc_wr(pc_wr), .S_Mux_A(S_Mux_A),
    .S_Mux_B(S_Mux_B), .S_Mux_C(S_Mux_C), .REG_WR(REG_WR), .control_ALU(control_ALU),
    .state_o(state_o), .illegal_op(illegal_op), .timeout_err(timeout_err)
  );

  multicycle_control_unit #(.ALU_OP_W(4), .TIMEOUT(4), .ENABLE_JAL(0)) dut_nj (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .cero(cero), .mem_ready(mem_ready), .mem_req(nj_mem_req), .MEM_RD(nj_MEM_RD),
    .MEM_WR(nj_MEM_WR), .ir_wr(nj_ir_wr), .pc_wr(nj_pc_wr), .S_Mux_A(nj_S_Mux_A),
    .S_Mux_B(nj_S_Mux_B), .S_Mux_C(nj_S_Mux_C), .REG_WR(nj_REG_WR),
    .control_ALU(nj_control_ALU), .state_o(nj_state_o), .illegal_op(nj_illegal_op),
    .timeout_err(nj_timeout_err)
  );

  // Apply reset for one edge; returns just after release, inside the first FETCH cycle.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    mem_ready = 1'b0;
    #1;
    n_cmp++;
    if ({mem_req, MEM_RD, MEM_WR, ir_wr, pc_wr, REG_WR} !== 6'b0 ||
        {S_Mux_A, S_Mux_B, S_Mux_C} !== 6'b0 || control_ALU !== 4'd0) begin
      n_bad++;
      $display("FAIL rst_held_outputs: enables=%b muxes=%b alu=%0d, required all 0",
               {mem_req, MEM_RD, MEM_WR, ir_wr, pc_wr, REG_WR},
               {S_Mux_A, S_Mux_B, S_Mux_C}, control_ALU);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (state_o !== 3'd0 || mem_req !== 1'b1 || illegal_op !== 1'b0 || timeout_err !== 1'b0) begin
      n_bad++;
      $display("FAIL post_reset: state=%0d mem_req=%b ill=%b tmo=%b, required 0 1 0 0",
               state_o, mem_req, illegal_op, timeout_err);
    end
  endtask

  // Drives one instruction from FETCH until it returns to FETCH or traps.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                           input logic z, input int fetch_wait, input int mem_wait);
    int  fcnt = 0;
    int  mcnt = 0;
    logic left = 1'b0;
    logic done = 1'b0;
    logic [2:0] st;
    opcode = op; funct3 = f3; funct7_5 = f7; cero = z;
    obs_cycles = 0; obs_regwr = 0; obs_trap = 0; obs_req_gap = 0; obs_memwr = 0;
    obs_ex_pcwr = 1'bx; obs_ex_alu = 'x; obs_ex_muxa = 'x; obs_ex_muxb = 'x;
    obs_wb_muxc = 'x; obs_wb_muxb = 'x;
    while (!done && obs_cycles < 40) begin
      @(negedge clk);
      st = state_o;
      if (st == 3'd0)      mem_ready = (fcnt == fetch_wait);
      else if (st == 3'd3) mem_ready = (mcnt == mem_wait);
      else                 mem_ready = 1'b0;
      #1;
      if (st == 3'd2) begin
        obs_ex_alu = control_ALU; obs_ex_pcwr = pc_wr;
        obs_ex_muxa = S_Mux_A; obs_ex_muxb = S_Mux_B;
      end
      if (st == 3'd4) begin
        obs_wb_muxc = S_Mux_C; obs_wb_muxb = S_Mux_B;
      end
      if (REG_WR) obs_regwr++;
      if (MEM_WR) obs_memwr = 1'b1;
      if ((st == 3'd0 || st == 3'd3) && mem_req !== 1'b1) obs_req_gap = 1'b1;
      if (st == 3'd0) fcnt++;
      if (st == 3'd3) mcnt++;
      obs_cycles++;
      @(posedge clk);
      #1;
      if (st != 3'd0) left = 1'b1;
      if (state_o == 3'd7) begin
        obs_trap = 1'b1;
        done = 1'b1;
      end else if (left && state_o == 3'd0) begin
        done = 1'b1;
      end
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL instr_bound: op=%b did not finish within %0d cycles", op, obs_cycles);
    end
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_reset_mid_mem();
    do_reset();
    opcode = OP_LD; funct3 = 3'b010; funct7_5 = 1'b0;
    @(negedge clk); mem_ready = 1'b1;   // FETCH
    @(negedge clk); mem_ready = 1'b0;   // DECODE
    @(negedge clk);                     // EXEC
    @(negedge clk); #1;                 // MEM
    n_cmp++;
    if (state_o !== 3'd3 || mem_req !== 1'b1 || MEM_RD !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_mem_state: state=%0d req=%b rd=%b, required 3 1 1", state_o, mem_req, MEM_RD);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++;
    if (mem_req !== 1'b0 || REG_WR !== 1'b0 || MEM_RD !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_mem_rst: req=%b regwr=%b rd=%b, required 0 0 0", mem_req, REG_WR, MEM_RD);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (state_o !== 3'd0 || mem_req !== 1'b1 || MEM_WR !== 1'b0 || MEM_RD !== 1'b1) begin
      n_bad++;
      $display("FAIL after_mid_rst: state=%0d req=%b wr=%b rd=%b, required 0 1 0 1",
               state_o, mem_req, MEM_WR, MEM_RD);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      n_cmp++;
      if (REG_WR !== 1'b0 || state_o !== 3'd0) begin
        n_bad++;
        $display("FAIL no_regwr_after_rst[%0d]: regwr=%b state=%0d, required 0 0", i, REG_WR, state_o);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    // ADD
    run_instr(OP_R, 3'b000, 1'b0, 1'b0, 0, 0);
    n_cmp++;
    if (obs_cycles !== 4 || obs_ex_alu !== 4'd0 || obs_wb_muxc !== 2'b01 || obs_regwr !== 1 || obs_ex_muxb !== 2'b00) begin
      n_bad++;
      $display("FAIL add: cyc=%0d alu=%0d muxc=%b regwr=%0d muxb=%b, required 4 0 01 1 00",
               obs_cycles, obs_ex_alu, obs_wb_muxc, obs_regwr, obs_ex_muxb);
    end
    // SUB
    run_instr(OP_R, 3'b000, 1'b1, 1'b0, 0, 0);
    n_cmp++;
    if (obs_cycles !== 4 || obs_ex_alu !== 4'd1 || obs_wb_muxc !== 2'b01 || obs_regwr !== 1) begin
      n_bad++;
      $display("FAIL sub: cyc=%0d alu=%0d muxc=%b regwr=%0d, required 4 1 01 1",
               obs_cycles, obs_ex_alu, obs_wb_muxc, obs_regwr);
    end
    // ADDI with IR[30] set must still be ADD
    run_instr(OP_I, 3'b000, 1'b1, 1'b0, 0, 0);
    n_cmp++;
    if (obs_cycles !== 4 || obs_ex_alu !== 4'd0 || obs_wb_muxc !== 2'b01 || obs_regwr !== 1 || obs_ex_muxb !== 2'b01) begin
      n_bad++;
      $display("FAIL addi: cyc=%0d alu=%0d muxc=%b regwr=%0d muxb=%b, required 4 0 01 1 01",
               obs_cycles, obs_ex_alu, obs_wb_muxc, obs_regwr, obs_ex_muxb);
    end
    // LUI
    run_instr(OP_LUI, 3'b000, 1'b0, 1'b0, 0, 0);
    n_cmp++;
    if (obs_cycles !== 3 || obs_wb_muxc !== 2'b00 || obs_wb_muxb !== 2'b11 || obs_regwr !== 1) begin
      n_bad++;
      $display("FAIL lui: cyc=%0d muxc=%b muxb=%b regwr=%0d, required 3 00 11 1",
               obs_cycles, obs_wb_muxc, obs_wb_muxb, obs_regwr);
    end
    // Store
    run_instr(OP_ST, 3'b010, 1'b0, 1'b0, 0, 0);
    n_cmp++;
    if (obs_cycles !== 4 || obs_memwr !== 1'b1 || obs_regwr !== 0 || obs_ex_muxb !== 2'b10 || obs_ex_alu !== 4'd0) begin
      n_bad++;
      $display("FAIL store: cyc=%0d memwr=%b regwr=%0d muxb=%b alu=%0d, required 4 1 0 10 0",
               obs_cycles, obs_memwr, obs_regwr, obs_ex_muxb, obs_ex_alu);
    end
  endtask

  task automatic test_alu_ops();
    logic [6:0] t_op[8]  = '{OP_R, OP_R, OP_R, OP_I, OP_R, OP_R, OP_I, OP_R};
    logic [2:0] t_f3[8]  = '{3'b100, 3'b101, 3'b101, 3'b101, 3'b111, 3'b110, 3'b010, 3'b001};
    logic       t_f7[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [3:0] t_exp[8] = '{4'd4, 4'd8, 4'd7, 4'd8, 4'd2, 4'd3, 4'd5, 4'd6};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      run_instr(t_op[i], t_f3[i], t_f7[i], 1'b0, 0, 0);
      n_cmp++;
      if (obs_ex_alu !== t_exp[i] || obs_cycles !== 4) begin
        n_bad++;
        $display("FAIL alu_op[%0d]: alu=%0d cyc=%0d, required %0d 4", i, obs_ex_alu, obs_cycles, t_exp[i]);
      end
    end
  endtask

  task automatic test_branch();
    logic [2:0] t_f3[4] = '{3'b000, 3'b000, 3'b001, 3'b001};
    logic       t_z[4]  = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic       t_tk[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      run_instr(OP_BR, t_f3[i], 1'b0, t_z[i], 0, 0);
      n_cmp++;
      if (obs_cycles !== 3 || obs_ex_pcwr !== t_tk[i] || obs_ex_muxa !== 2'b01 ||
          obs_ex_alu !== 4'd1 || obs_regwr !== 0 || obs_ex_muxb !== 2'b00) begin
        n_bad++;
        $display("FAIL branch[%0d]: cyc=%0d pcwr=%b muxa=%b alu=%0d regwr=%0d, required 3 %b 01 1 0",
                 i, obs_cycles, obs_ex_pcwr, obs_ex_muxa, obs_ex_alu, obs_regwr, t_tk[i]);
      end
    end
  endtask

  task automatic test_load_wait();
    do_reset();
    run_instr(OP_LD, 3'b010, 1'b0, 1'b0, 3, 2);
    n_cmp++;
    if (obs_cycles !== 10 || obs_wb_muxc !== 2'b10 || obs_req_gap !== 1'b0 ||
        obs_regwr !== 1 || obs_trap !== 1'b0 || obs_ex_muxb !== 2'b01) begin
      n_bad++;
      $display("FAIL load_wait: cyc=%0d muxc=%b gap=%b regwr=%0d trap=%b muxb=%b, required 10 10 0 1 0 01",
               obs_cycles, obs_wb_muxc, obs_req_gap, obs_regwr, obs_trap, obs_ex_muxb);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    run_instr(OP_I, 3'b000, 1'b0, 1'b0, 1000, 0);
    n_cmp++;
    if (obs_trap !== 1'b1 || obs_cycles !== 5 || state_o !== 3'd7 ||
        timeout_err !== 1'b1 || illegal_op !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout_trap: trap=%b cyc=%0d state=%0d tmo=%b ill=%b, required 1 5 7 1 0",
               obs_trap, obs_cycles, state_o, timeout_err, illegal_op);
    end
    do_reset();
    run_instr(OP_I, 3'b000, 1'b0, 1'b0, 4, 0);
    n_cmp++;
    if (obs_trap !== 1'b0 || obs_cycles !== 8 || timeout_err !== 1'b0 || obs_regwr !== 1) begin
      n_bad++;
      $display("FAIL timeout_edge: trap=%b cyc=%0d tmo=%b regwr=%0d, required 0 8 0 1",
               obs_trap, obs_cycles, timeout_err, obs_regwr);
    end
  endtask

  task automatic test_illegal();
    logic [6:0] t_op[2] = '{7'b1111111, OP_BR};
    logic [2:0] t_f3[2] = '{3'b000, 3'b100};
    for (int i = 0; i < 2; i++) begin
      do_reset();
      run_instr(t_op[i], t_f3[i], 1'b0, 1'b0, 0, 0);
      n_cmp++;
      if (obs_trap !== 1'b1 || obs_cycles !== 2 || illegal_op !== 1'b1 || timeout_err !== 1'b0) begin
        n_bad++;
        $display("FAIL illegal[%0d]: trap=%b cyc=%0d ill=%b tmo=%b, required 1 2 1 0",
                 i, obs_trap, obs_cycles, illegal_op, timeout_err);
      end
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        mem_ready = 1'b1;
        #1;
        n_cmp++;
        if (mem_req !== 1'b0 || state_o !== 3'd7 || pc_wr !== 1'b0 || illegal_op !== 1'b1) begin
          n_bad++;
          $display("FAIL trap_hold[%0d.%0d]: req=%b state=%0d pcwr=%b ill=%b, required 0 7 0 1",
                   i, k, mem_req, state_o, pc_wr, illegal_op);
        end
      end
    end
  endtask

  task automatic test_jal();
    do_reset();
    run_instr(OP_JAL, 3'b000, 1'b0, 1'b0, 0, 0);
    n_cmp++;
    if (obs_cycles !== 4 || obs_ex_pcwr !== 1'b1 || obs_ex_muxa !== 2'b10 ||
        obs_wb_muxc !== 2'b11 || obs_regwr !== 1 || obs_trap !== 1'b0) begin
      n_bad++;
      $display("FAIL jal: cyc=%0d pcwr=%b muxa=%b muxc=%b regwr=%0d trap=%b, required 4 1 10 11 1 0",
               obs_cycles, obs_ex_pcwr, obs_ex_muxa, obs_wb_muxc, obs_regwr, obs_trap);
    end
    n_cmp++;
    if (nj_state_o !== 3'd7 || nj_illegal_op !== 1'b1 || nj_mem_req !== 1'b0) begin
      n_bad++;
      $display("FAIL jal_disabled: state=%0d ill=%b req=%b, required 7 1 0",
               nj_state_o, nj_illegal_op, nj_mem_req);
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_mem();
    test_back_to_back();
    test_alu_ops();
    test_branch();
    test_load_wait();
    test_timeout();
    test_illegal();
    test_jal();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
